// File: rtl/if_id_stage.sv
// IF stage with the IF/ID pipeline register: PC sequencing, fetch handshake,
// and branch/flush/stall resolution feeding the decode stage.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [6:0]  id_opcode
);

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] id_pc_nxt, id_instr_nxt;
  logic        id_valid_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      id_pc    <= 32'h0;
      id_instr <= NOP_INSTR;
      id_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_pc    <= id_pc_nxt;
      id_instr <= id_instr_nxt;
      id_valid <= id_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    id_pc_nxt    = id_pc;
    id_instr_nxt = id_instr;
    id_valid_nxt = id_valid;
    imem_req     = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, WAIT: begin
        imem_req = 1'b1;
        // A redirect in WAIT drops the outstanding fetch; any late data for
        // the old address arrives while pc already points at the target.
        if (branch_taken) begin
          pc_nxt       = {branch_target[31:2], 2'b00};
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          state_nxt    = RUN;
        end else if (flush) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          state_nxt    = RUN;
        end else if (stall) begin
          state_nxt    = state;
        end else if (!imem_valid) begin
          id_instr_nxt = NOP_INSTR;
          id_valid_nxt = 1'b0;
          state_nxt    = WAIT;
        end else begin
          id_pc_nxt    = pc;
          id_instr_nxt = imem_rdata;
          id_valid_nxt = 1'b1;
          pc_nxt       = pc + 32'd4;
          state_nxt    = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  assign imem_addr = pc;
  assign id_opcode = id_instr[6:0];

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), meaning the bubble instruction word.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  input  1  hazard-unit hold request.
REQ-006 SHALL have port flush  input  1  discard IF/ID contents.
REQ-007 SHALL have port branch_taken  input  1  redirect request from EX.
REQ-008 SHALL have port branch_target  input  32  redirect address.
REQ-009 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-010 SHALL have port imem_addr  output  32  fetch address.
REQ-011 SHALL have port imem_rdata  input  32  instruction word for imem_addr.
REQ-012 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-013 SHALL have port id_pc  output  32  PC of instruction held in IF/ID.
REQ-014 SHALL have port id_instr  output  32  instruction held in IF/ID.
REQ-015 SHALL have port id_valid  output  1  IF/ID holds a real instruction.
REQ-016 SHALL have port id_opcode  output  7  id_instr[6:0], the Opcode input of the decode-stage control unit.

Function
REQ-017 SHALL implement states BOOT, RUN, WAIT in one state register.
REQ-018 SHALL drive imem_req=0 in BOOT, 1 in RUN and WAIT; imem_addr=pc combinationally in every state.
REQ-019 SHALL move BOOT->RUN unconditionally one cycle after reset deasserts; no IF/ID load, pc unchanged in BOOT.
REQ-020 SHALL, in RUN/WAIT, resolve each cycle with priority branch_taken > flush > stall > imem_valid.
REQ-021 SHALL on branch_taken: pc <= {branch_target[31:2],2'b00}; IF/ID <= bubble; state <= RUN; stall and imem_valid ignored.
REQ-022 SHALL on flush without branch_taken: IF/ID <= bubble; pc unchanged (same address refetched); state <= RUN.
REQ-023 SHALL on stall (no branch_taken, no flush): pc, IF/ID and state all hold.
REQ-024 SHALL on imem_valid=0 (no higher event): pc holds; IF/ID <= bubble; state <= WAIT.
REQ-025 SHALL on imem_valid=1 (no higher event): id_pc <= pc; id_instr <= imem_rdata; id_valid <= 1; pc <= pc+4; state <= RUN.
REQ-026 SHALL compute pc+4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-027 SHALL define bubble as id_instr=NOP_INSTR, id_valid=0, id_pc unchanged.
REQ-028 SHALL abandon a pending fetch in WAIT on branch_taken; a late imem_valid for the old address is not captured.
REQ-029 SHALL give one-cycle fetch latency: instruction at imem_addr in cycle N appears on id_instr in N+1.
REQ-030 SHALL derive id_opcode purely from id_instr, never from imem_rdata.

Reset
REQ-031 SHALL on reset low, asynchronously and regardless of clk: pc=RESET_PC, state=BOOT, id_pc=0, id_instr=NOP_INSTR, id_valid=0.
REQ-032 SHALL therefore drive id_opcode=7'b0010011 and imem_req=0 throughout reset.
REQ-033 SHALL, on reset asserted mid-WAIT or mid-stall, discard all pending state and restart from BOOT.

Verification
REQ-034 SHALL cover boot: release reset, imem_valid=1, rdata 0x00500093 -> cycle 1 imem_req=1 addr 0; cycle 2 id_instr=0x00500093, id_pc=0, id_valid=1, imem_addr=4.
REQ-035 SHALL cover stall: stall=1 for 3 cycles at pc=8 -> imem_addr stays 8, id_* unchanged; release -> next capture id_pc=8.
REQ-036 SHALL cover branch vs stall: branch_taken=1, stall=1, target 0x103 at pc=0x20 -> next pc=0x100, id_valid=0, id_instr=0x00000013.
REQ-037 SHALL cover memory wait: imem_valid=0 two cycles at pc=0x10 -> state WAIT, pc stays 0x10, bubbles; imem_valid=1 -> id_pc=0x10.
REQ-038 SHALL cover wrap: pc=0xFFFFFFFC, valid fetch -> id_pc=0xFFFFFFFC, next imem_addr=0.
REQ-039 SHALL cover async reset mid-WAIT: reset low between edges -> outputs immediately at reset values, id_opcode=7'b0010011.
